// File: rtl/tftp_tx_encode.sv
// TFTP transmit packet builder: serialises DATA, ACK and ERROR packets as a byte
// stream with a valid/ready handshake, passing DATA payload straight through.
module tftp_tx_encode #(
    parameter int MAX_PAYLOAD = 512,
    parameter int LEN_W       = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       pkt_type,
    input  logic [15:0]      field,
    input  logic [LEN_W-1:0] payload_len,
    input  logic [7:0]       pl_data,
    input  logic             pl_valid,
    output logic             pl_ready,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             tx_last,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        IDLE,
        OP_HI,
        OP_LO,
        F_HI,
        F_LO,
        PAYLOAD,
        TERM
    } state_t;

    localparam logic [1:0]       T_DATA  = 2'd0;
    localparam logic [1:0]       T_ACK   = 2'd1;
    localparam logic [1:0]       T_ERR   = 2'd2;
    localparam logic [1:0]       T_RSV   = 2'd3;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PAYLOAD);

    state_t           state;
    logic [1:0]       typ;
    logic [15:0]      fld;
    logic [LEN_W-1:0] remaining;
    logic [7:0]       data_r;
    logic             hdr_valid;
    logic             hdr_last;

    logic in_payload;
    logic beat;
    logic final_pl;

    assign in_payload = (state == PAYLOAD);
    assign beat       = tx_valid && tx_ready;
    assign final_pl   = (remaining == LEN_W'(1));

    // Header/terminator bytes come from registers; payload bytes bypass them so
    // the source sees the sink's ready with no added latency.
    assign tx_data  = in_payload ? pl_data : data_r;
    assign tx_valid = in_payload ? pl_valid : hdr_valid;
    assign tx_last  = in_payload ? (pl_valid && final_pl) : hdr_last;
    assign pl_ready = in_payload && tx_ready;

    // NOTE: every register below is assigned with <= so all of them update
    // together on the edge and no read sees a half-updated state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            typ       <= T_DATA;
            fld       <= '0;
            remaining <= '0;
            data_r    <= '0;
            hdr_valid <= 1'b0;
            hdr_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && pkt_type != T_RSV) begin
                        typ       <= pkt_type;
                        fld       <= field;
                        remaining <= (payload_len > MAX_LEN) ? MAX_LEN : payload_len;
                        data_r    <= 8'h00;
                        hdr_valid <= 1'b1;
                        hdr_last  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= OP_HI;
                    end
                end

                OP_HI: begin
                    if (beat) begin
                        data_r <= 8'(typ) + 8'd3;
                        state  <= OP_LO;
                    end
                end

                OP_LO: begin
                    if (beat) begin
                        data_r <= fld[15:8];
                        state  <= F_HI;
                    end
                end

                F_HI: begin
                    if (beat) begin
                        data_r   <= fld[7:0];
                        hdr_last <= (typ == T_ACK) ||
                                    (typ == T_DATA && remaining == '0);
                        state    <= F_LO;
                    end
                end

                F_LO: begin
                    if (beat) begin
                        if (typ == T_ERR) begin
                            data_r   <= 8'h00;
                            hdr_last <= 1'b1;
                            state    <= TERM;
                        end else if (typ == T_DATA && remaining != '0) begin
                            hdr_valid <= 1'b0;
                            hdr_last  <= 1'b0;
                            state     <= PAYLOAD;
                        end else begin
                            data_r    <= 8'h00;
                            hdr_valid <= 1'b0;
                            hdr_last  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end

                PAYLOAD: begin
                    if (beat) begin
                        remaining <= remaining - LEN_W'(1);
                        if (final_pl) begin
                            data_r <= 8'h00;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                end

                TERM: begin
                    if (beat) begin
                        data_r    <= 8'h00;
                        hdr_valid <= 1'b0;
                        hdr_last  <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tftp_tx_encode.sv
// Directed bench for tftp_tx_encode: byte-stream checks for each packet type,
// stalls, payload saturation, reset mid-packet and ignored starts.
module tb_tftp_tx_encode;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  pkt_type;
    logic [15:0] field;
    logic [9:0]  payload_len;
    logic [7:0]  pl_data;
    logic        pl_valid;
    logic        pl_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_last;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;

    // Payload source and sink-ready pattern
    logic [7:0] pl_mem [0:1023];
    int         pl_n = 0;
    int         pl_idx = 0;
    logic       pl_clear = 1'b0;
    logic       ready_mode = 1'b0;
    logic [7:0] cyc = '0;

    // Monitor state
    logic [7:0] got_data [$];
    logic       got_last [$];
    int         done_cnt = 0;
    int         stall_cnt = 0;
    int         stall_bad = 0;
    int         done_busy_bad = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;

    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    tftp_tx_encode dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pkt_type   (pkt_type),
        .field      (field),
        .payload_len(payload_len),
        .pl_data    (pl_data),
        .pl_valid   (pl_valid),
        .pl_ready   (pl_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_last    (tx_last),
        .busy       (busy),
        .done       (done)
    );

    assign pl_valid = (pl_idx < pl_n);
    assign pl_data  = pl_mem[pl_idx[9:0]];
    assign tx_ready = ready_mode ? cyc[0] : 1'b1;

    always @(posedge clk) begin
        cyc <= cyc + 8'd1;
        if (pl_clear)
            pl_idx <= 0;
        else if (pl_valid && pl_ready)
            pl_idx <= pl_idx + 1;
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (prev_stall && (tx_data !== prev_data || !tx_valid))
                stall_bad <= stall_bad + 1;
            if (tx_valid && !tx_ready)
                stall_cnt <= stall_cnt + 1;
            if (tx_valid && tx_ready) begin
                got_data.push_back(tx_data);
                got_last.push_back(tx_last);
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                if (busy) done_busy_bad <= done_busy_bad + 1;
            end
            prev_stall <= tx_valid && !tx_ready;
            prev_data  <= tx_data;
        end else begin
            prev_stall <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_src(input int n);
        pl_n     = n;
        pl_clear = 1'b1;
        step(1);
        pl_clear = 1'b0;
    endtask

    // Pulses start for one cycle, then scrambles the inputs that must only be
    // sampled at acceptance.
    task automatic send(input logic [1:0] t, input logic [15:0] f, input logic [9:0] len,
                        input bit check_lat);
        pkt_type    = t;
        field       = f;
        payload_len = len;
        start       = 1'b1;
        step(1);
        start       = 1'b0;
        pkt_type    = 2'd2;
        field       = 16'hDEAD;
        payload_len = 10'd1;
        if (check_lat) begin
            check("lat_valid", {31'd0, tx_valid}, 32'd1);
            check("lat_byte", {24'd0, tx_data}, 32'h00);
        end
    endtask

    task automatic wait_done(input int done_base);
        for (int i = 0; i < 3000 && done_cnt <= done_base; i++)
            step(1);
        step(4);
    endtask

    task automatic compare(input string tag, input int base, input int done_base,
                           input int stall_base);
        int n;
        int last_pos;
        int last_cnt;
        n        = got_data.size() - base;
        last_pos = -1;
        last_cnt = 0;
        check({tag, "_len"}, n, exp_q.size());
        for (int i = 0; i < exp_q.size() && base + i < got_data.size(); i++)
            check($sformatf("%s_b%0d", tag, i), {24'd0, got_data[base+i]}, {24'd0, exp_q[i]});
        for (int i = base; i < got_data.size(); i++) begin
            if (got_last[i]) begin
                if (last_pos < 0) last_pos = i - base;
                last_cnt++;
            end
        end
        check({tag, "_last_pos"}, last_pos, exp_q.size() - 1);
        check({tag, "_last_cnt"}, last_cnt, 1);
        check({tag, "_done_cnt"}, done_cnt - done_base, 1);
        check({tag, "_stable"}, stall_bad - stall_base, 0);
        check({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int base;
        int dbase;
        int sbase;
        int scnt;

        reset       = 1'b1;
        start       = 1'b0;
        pkt_type    = 2'd0;
        field       = '0;
        payload_len = '0;
        step(3);
        check("rst_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_last", {31'd0, tx_last}, 32'd0);
        check("rst_pl_ready", {31'd0, pl_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_data", {24'd0, tx_data}, 32'd0);
        reset = 1'b0;
        step(2);

        // ACK 0x0102, sink always ready: 4 beats, done right after the 4th
        base = got_data.size(); dbase = done_cnt; sbase = stall_bad;
        send(2'd1, 16'h0102, 10'd0, 1'b1);
        step(4);
        check("ack_done_pulse", {31'd0, done}, 32'd1);
        check("ack_done_busy", {31'd0, busy}, 32'd0);
        step(1);
        check("ack_done_width", {31'd0, done}, 32'd0);
        step(2);
        exp_q = '{8'h00, 8'h04, 8'h01, 8'h02};
        compare("ack", base, dbase, sbase);

        // DATA len=3 with a toggling sink
        pl_mem[0] = 8'hAA; pl_mem[1] = 8'hBB; pl_mem[2] = 8'hCC;
        load_src(3);
        ready_mode = 1'b1;
        base = got_data.size(); dbase = done_cnt; sbase = stall_bad; scnt = stall_cnt;
        send(2'd0, 16'h0007, 10'd3, 1'b1);
        wait_done(dbase);
        ready_mode = 1'b0;
        exp_q = '{8'h00, 8'h03, 8'h00, 8'h07, 8'hAA, 8'hBB, 8'hCC};
        compare("data3", base, dbase, sbase);
        check("data3_stalled", {31'd0, (stall_cnt - scnt) > 0}, 32'd1);

        // ERROR code 1
        base = got_data.size(); dbase = done_cnt; sbase = stall_bad;
        send(2'd2, 16'h0001, 10'd0, 1'b1);
        wait_done(dbase);
        exp_q = '{8'h00, 8'h05, 8'h00, 8'h01, 8'h00};
        compare("err", base, dbase, sbase);

        // DATA len=0: header only, last on F_LO
        load_src(0);
        base = got_data.size(); dbase = done_cnt; sbase = stall_bad;
        send(2'd0, 16'h00FF, 10'd0, 1'b1);
        wait_done(dbase);
        exp_q = '{8'h00, 8'h03, 8'h00, 8'hFF};
        compare("data0", base, dbase, sbase);

        // DATA len=600 saturates to 512; the source offers 600
        for (int i = 0; i < 1024; i++) pl_mem[i] = 8'(i);
        load_src(600);
        base = got_data.size(); dbase = done_cnt; sbase = stall_bad;
        send(2'd0, 16'h0009, 10'd600, 1'b1);
        wait_done(dbase);
        exp_q = '{8'h00, 8'h03, 8'h00, 8'h09};
        for (int i = 0; i < 512; i++) exp_q.push_back(8'(i));
        compare("data600", base, dbase, sbase);
        check("data600_src_taken", pl_idx, 512);

        // start while busy is dropped
        base = got_data.size(); dbase = done_cnt; sbase = stall_bad;
        send(2'd1, 16'h0A0B, 10'd0, 1'b1);
        step(1);
        pkt_type = 2'd2;
        start    = 1'b1;
        step(1);
        start    = 1'b0;
        wait_done(dbase);
        step(6);
        exp_q = '{8'h00, 8'h04, 8'h0A, 8'h0B};
        compare("busy_start", base, dbase, sbase);

        // Reserved type: nothing happens
        base = got_data.size(); dbase = done_cnt;
        send(2'd3, 16'h1234, 10'd0, 1'b0);
        check("rsv_busy", {31'd0, busy}, 32'd0);
        step(10);
        check("rsv_bytes", got_data.size() - base, 0);
        check("rsv_done", done_cnt - dbase, 0);

        // Reset in the middle of a payload
        for (int i = 0; i < 8; i++) pl_mem[i] = 8'h50 + 8'(i);
        load_src(8);
        base = got_data.size(); dbase = done_cnt;
        send(2'd0, 16'h0003, 10'd5, 1'b1);
        for (int i = 0; i < 200 && got_data.size() - base < 6; i++)
            step(1);
        check("rstmid_in_payload", {31'd0, tx_valid && pl_ready}, 32'd1);
        reset = 1'b1;
        step(1);
        check("rstmid_valid", {31'd0, tx_valid}, 32'd0);
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        check("rstmid_pl_ready", {31'd0, pl_ready}, 32'd0);
        reset = 1'b0;
        step(10);
        check("rstmid_done", done_cnt - dbase, 0);
        check("rstmid_idle_valid", {31'd0, tx_valid}, 32'd0);

        check("done_while_busy", done_busy_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
